dsc_mul_seq: RTL and testbench

Operand sequencer and result capture stage for the 4-input, 4-bit deterministic stochastic multiplier core. It accepts one operand tuple through a valid/ready handshake, clears and runs the core, and detects completion either by the full-length cycle count or by the core's `ov` flag. It then latches the core's 16-bit binary count and presents it downstream through a second valid/ready handshake. It sits between the operand source and the core, owns the core's `a`/`b`/`c`/`d`/`en`/`rst` pins, and consumes its `z`/`ov` outputs.

---
 rtl/dsc_mul_seq_if.sv | 50 +++++
 rtl/dsc_mul_seq.sv | 134 +++++++++++++
 tb/tb_dsc_mul_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsc_mul_seq_if.sv
// dsc_mul_seq_if: bundle of every non-clock signal of the stochastic-multiplier
// sequencer. The master modport is the sequencer itself. The slave modport is
// the surrounding environment: the operand source, the core and the result sink.
//
// Operand side : in_valid, in_ready, in_a..in_d (SNG_W each)
// Core side    : core_a..core_d (SNG_W each), core_clr, core_en,
//                core_z (Z_W), core_ov
// Result side  : out_valid, out_ready, out_z (Z_W), out_cyc (Z_W+1), out_early
// Status       : busy
interface dsc_mul_seq_if #(
  parameter int SNG_W = 4
);
  localparam int Z_W = 4 * SNG_W;

  logic             in_valid;
  logic             in_ready;
  logic [SNG_W-1:0] in_a;
  logic [SNG_W-1:0] in_b;
  logic [SNG_W-1:0] in_c;
  logic [SNG_W-1:0] in_d;

  logic [SNG_W-1:0] core_a;
  logic [SNG_W-1:0] core_b;
  logic [SNG_W-1:0] core_c;
  logic [SNG_W-1:0] core_d;
  logic             core_clr;
  logic             core_en;
  logic [Z_W-1:0]   core_z;
  logic             core_ov;

  logic             out_valid;
  logic             out_ready;
  logic [Z_W-1:0]   out_z;
  logic [Z_W:0]     out_cyc;
  logic             out_early;

  logic             busy;

  modport master (
    input  in_valid, in_a, in_b, in_c, in_d, core_z, core_ov, out_ready,
    output in_ready, core_a, core_b, core_c, core_d, core_clr, core_en,
           out_valid, out_z, out_cyc, out_early, busy
  );

  modport slave (
    output in_valid, in_a, in_b, in_c, in_d, core_z, core_ov, out_ready,
    input  in_ready, core_a, core_b, core_c, core_d, core_clr, core_en,
           out_valid, out_z, out_cyc, out_early, busy
  );
endinterface

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: operand sequencer and result capture stage for the 4-input
// deterministic stochastic multiplier core.
//
// The sequencer accepts one operand tuple and clears the core. It then runs the
// core until the full-length cycle count is reached, or until core_ov ends the
// run early. It latches the core count and holds it for a valid/ready consumer.
//
// Parameters : SNG_W - operand width (Z_W = 4*SNG_W, FULL = 2**Z_W)
//              GUARD - number of RUN cycles after the clear during which
//                      core_ov is ignored
// Ports      : clk  - rising-edge clock
//              rst  - asynchronous active-low reset
//              bus  - dsc_mul_seq_if.master (operand, core, result and busy
//                     signals)
// Option     : DSC_SEQ_EARLY_EXIT_EN - when defined, core_ov ends RUN early
//              once the count reaches GUARD. When undefined, every run lasts
//              FULL cycles and out_early stays 0.
module dsc_mul_seq #(
  parameter int SNG_W = 4,
  parameter int GUARD = 2
) (
  input  logic           clk,
  input  logic           rst,
  dsc_mul_seq_if.master  bus
);
  localparam int           Z_W     = 4 * SNG_W;
  localparam int           FULL    = 1 << Z_W;
  localparam logic [Z_W:0] LAST    = (Z_W+1)'(FULL - 1);
  localparam logic [Z_W:0] GUARD_C = (Z_W+1)'(GUARD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t       state;
  logic [Z_W:0] cnt;
  logic         at_last;
  logic         ov_hit;

  assign at_last = (cnt == LAST);

`ifdef DSC_SEQ_EARLY_EXIT_EN
  // The core's flag may still reflect stale counters just after the clear.
  assign ov_hit = bus.core_ov && (cnt >= GUARD_C);
`else
  logic unused_ov;
  assign unused_ov = bus.core_ov;
  assign ov_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.core_a    <= '0;
      bus.core_b    <= '0;
      bus.core_c    <= '0;
      bus.core_d    <= '0;
      bus.core_clr  <= 1'b1;
      bus.core_en   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_z     <= '0;
      bus.out_cyc   <= '0;
      bus.out_early <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.core_clr <= 1'b0;
          if (bus.in_valid && bus.in_ready) begin
            bus.core_a   <= bus.in_a;
            bus.core_b   <= bus.in_b;
            bus.core_c   <= bus.in_c;
            bus.core_d   <= bus.in_d;
            bus.in_ready <= 1'b0;
            bus.core_clr <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= CLEAR;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end

        CLEAR: begin
          cnt          <= '0;
          bus.core_clr <= 1'b0;
          bus.core_en  <= 1'b1;
          state        <= RUN;
        end

        RUN: begin
          cnt <= cnt + 1'b1;
          if (at_last || ov_hit) begin
            // A flag coinciding with the last count is still a full run.
            bus.out_cyc   <= cnt + 1'b1;
            bus.out_early <= ov_hit && !at_last;
            bus.core_en   <= 1'b0;
            state         <= CAPTURE;
          end
        end

        CAPTURE: begin
          // The core registered its final increment on the last RUN edge.
          bus.out_z     <= bus.core_z;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end

        HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.core_en   <= 1'b0;
          bus.core_clr  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb_dsc_mul_seq: bench for dsc_mul_seq, built with SNG_W=2 so that a full run
// lasts 256 cycles. A small core model produces the stochastic counts. Each
// full-length run should yield a*b*c*d.
module tb_dsc_mul_seq;
  localparam int SNG_W = 2;
  localparam int GUARD = 2;
  localparam int Z_W   = 4 * SNG_W;
  localparam int FULL  = 1 << Z_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsc_mul_seq_if #(.SNG_W(SNG_W)) bus ();

  dsc_mul_seq #(.SNG_W(SNG_W), .GUARD(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core model. Enabled cycle n is split into four SNG_W-bit digits. Stream i
  // is high while digit i is below operand i. The count accumulates the cycles
  // on which all four streams are high.
  function automatic bit hit(input int n, input int a, input int b, input int c, input int d);
    int m;
    m = (1 << SNG_W) - 1;
    return ((n & m) < a) && (((n >> SNG_W) & m) < b) &&
           (((n >> (2*SNG_W)) & m) < c) && (((n >> (3*SNG_W)) & m) < d);
  endfunction

  logic [Z_W-1:0] cz;
  logic [Z_W:0]   cn;
  int             ov_lo = 1;
  int             ov_hi = 0;

  always_ff @(posedge clk) begin
    if (bus.core_clr) begin
      cz <= '0;
      cn <= '0;
    end else if (bus.core_en) begin
      if (hit(int'(cn), int'(bus.core_a), int'(bus.core_b), int'(bus.core_c), int'(bus.core_d)))
        cz <= cz + 1'b1;
      cn <= cn + 1'b1;
    end
  end

  assign bus.core_z  = cz;
  assign bus.core_ov = bus.core_en && (int'(cn) >= ov_lo) && (int'(cn) <= ov_hi);

  // Reference model: the exit point and the expected count.
  function automatic int model_k(input int lo, input int hi);
`ifdef DSC_SEQ_EARLY_EXIT_EN
    for (int n = GUARD; n < FULL; n++)
      if (n >= lo && n <= hi) return n;
`endif
    return FULL - 1;
  endfunction

  function automatic int model_z(input int a, input int b, input int c, input int d, input int k);
    int s;
    s = 0;
    for (int n = 0; n <= k; n++)
      if (hit(n, a, b, c, d)) s++;
    return s;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int a, b, c, d, lo, hi;
    int z, cyc, early, lat;
  } vec_t;

  vec_t vecs[10];

  task automatic send(input int a, input int b, input int c, input int d, input bit keep);
    int t;
    @(negedge clk);
    bus.in_a     = SNG_W'(a);
    bus.in_b     = SNG_W'(b);
    bus.in_c     = SNG_W'(c);
    bus.in_d     = SNG_W'(d);
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
    check("clear_pulse", {bus.core_clr, bus.core_en, bus.busy}, 3'b101);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < FULL + 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake(input int stall);
    logic [Z_W-1:0] z0;
    logic [Z_W:0]   c0;
    z0 = bus.out_z;
    c0 = bus.out_cyc;
    bus.out_ready = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      check("stall_z", bus.out_z, z0);
      check("stall_cyc", bus.out_cyc, c0);
      check("stall_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b101);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("after_hs", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.in_d      = '0;
    bus.out_ready = 1'b0;

    // Fixed vectors: a..d, ov window, expected z, cyc, early, latency.
    vecs[0] = '{3, 3, 3, 3, 1, 0, 81, 256, 0, 259};
    vecs[1] = '{2, 2, 2, 2, 1, 0, 16, 256, 0, 259};
`ifdef DSC_SEQ_EARLY_EXIT_EN
    vecs[2] = '{3, 3, 3, 0, 0, FULL, 0, 3, 1, 6};
    vecs[5] = '{3, 3, 3, 3, 40, 40, 25, 41, 1, 44};
`else
    vecs[2] = '{3, 3, 3, 0, 0, FULL, 0, 256, 0, 259};
    vecs[5] = '{3, 3, 3, 3, 40, 40, 81, 256, 0, 259};
`endif
    vecs[3] = '{3, 2, 1, 3, 0, 1, 18, 256, 0, 259};
    vecs[4] = '{1, 1, 1, 1, FULL-1, FULL-1, 1, 256, 0, 259};
    for (int i = 6; i < 10; i++) begin
      int k;
      vecs[i].a  = int'($urandom_range(0, 3));
      vecs[i].b  = int'($urandom_range(0, 3));
      vecs[i].c  = int'($urandom_range(0, 3));
      vecs[i].d  = int'($urandom_range(0, 3));
      vecs[i].lo = int'($urandom_range(0, FULL + 20));
      vecs[i].hi = vecs[i].lo + int'($urandom_range(0, 2));
      k = model_k(vecs[i].lo, vecs[i].hi);
      vecs[i].z     = model_z(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, k);
      vecs[i].cyc   = k + 1;
      vecs[i].early = (k != FULL - 1) ? 1 : 0;
      vecs[i].lat   = k + 4;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready_clr", {bus.in_ready, bus.core_clr, bus.core_en}, 3'b010);
    check("rst_out", {bus.out_valid, bus.out_early, bus.busy}, 3'b000);
    check("rst_data", {bus.out_z, bus.out_cyc, bus.core_a, bus.core_d}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {bus.in_ready, bus.busy}, 2'b10);

    // Table-driven runs; the first one also exercises backpressure.
    for (int i = 0; i < 10; i++) begin
      ov_lo = vecs[i].lo;
      ov_hi = vecs[i].hi;
      send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 1'b0);
      wait_result(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_z", i), bus.out_z, vecs[i].z);
      check($sformatf("v%0d_cyc", i), bus.out_cyc, vecs[i].cyc);
      check($sformatf("v%0d_early", i), bus.out_early, vecs[i].early);
      check($sformatf("v%0d_ops", i), {bus.core_a, bus.core_b, bus.core_c, bus.core_d},
            (vecs[i].a << 6) | (vecs[i].b << 4) | (vecs[i].c << 2) | vecs[i].d);
      check($sformatf("v%0d_hold", i), {bus.in_ready, bus.busy, bus.core_en}, 3'b010);
      handshake((i == 0) ? 10 : 0);
    end

    // Back-to-back tuples with in_valid held high.
    ov_lo = 1;
    ov_hi = 0;
    send(3, 3, 3, 3, 1'b1);
    bus.in_a = 2'd2;
    bus.in_b = 2'd2;
    bus.in_c = 2'd2;
    bus.in_d = 2'd2;
    wait_result(lat);
    check("b2b_first_z", bus.out_z, 81);
    check("b2b_no_accept", {bus.in_ready, bus.busy}, 2'b01);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_idle", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_second_accept", {bus.busy, bus.core_clr, bus.core_a}, {1'b1, 1'b1, 2'd2});
    wait_result(lat);
    check("b2b_lat", lat, FULL + 3);
    check("b2b_second_z", bus.out_z, 16);
    handshake(0);

    // Reset in the middle of a run.
    send(3, 3, 3, 3, 1'b0);
    lat = 0;
    while (int'(cn) != 100 && lat < FULL + 20) begin
      @(negedge clk);
      lat++;
    end
    check("midrun_reached", cn, 100);
    rst = 1'b0;
    #1;
    check("midrun_rst_ctl", {bus.in_ready, bus.core_clr, bus.core_en, bus.busy}, 4'b0100);
    check("midrun_rst_out", {bus.out_valid, bus.out_early, bus.out_z, bus.out_cyc, bus.core_a}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(3, 3, 3, 3, 1'b0);
    wait_result(lat);
    check("after_rst_lat", lat, FULL + 3);
    check("after_rst_z", bus.out_z, 81);
    check("after_rst_cyc", bus.out_cyc, FULL);
    handshake(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
